// File: rtl/clasificador_argmax.sv
// Output-stage argmax classifier: ReLU on each streamed neuron result, tracks the
// running maximum and its index, and holds the per-frame winner until it is accepted.
module clasificador_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 8,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_class,
    output logic [DATA_W-1:0] out_score,
    input  logic              out_ready,
    output logic              err_len
);

    typedef enum logic [1:0] {ACC, DROP, HOLD} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  arg;
    logic [DATA_W-1:0] max_q;

    logic              accept;
    logic [DATA_W-1:0] relu;
    logic              take;
    logic [DATA_W-1:0] cand_max;
    logic [IDX_W-1:0]  cand_arg;

    // in_ready is the only combinational output; it is held low during reset.
    assign in_ready = !rst && (state != HOLD);
    assign accept   = in_valid && in_ready;
    assign relu     = in_data[DATA_W-1] ? '0 : in_data;

    // Strict greater-than keeps the lowest index on ties; beat 0 always loads.
    assign take     = (idx == '0) || (relu > max_q);
    assign cand_max = take ? relu : max_q;
    assign cand_arg = take ? idx : arg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            idx       <= '0;
            arg       <= '0;
            max_q     <= '0;
            out_valid <= 1'b0;
            out_class <= '0;
            out_score <= '0;
            err_len   <= 1'b0;
        end else begin
            // NOTE: err_len defaults low every cycle so a later assignment in this block makes a one-cycle pulse.
            err_len <= 1'b0;
            case (state)
                ACC: begin
                    if (accept) begin
                        max_q <= cand_max;
                        arg   <= cand_arg;
                        if (in_last) begin
                            idx <= '0;
                            if (idx == LAST_IDX) begin
                                out_class <= cand_arg;
                                out_score <= cand_max;
                                out_valid <= 1'b1;
                                state     <= HOLD;
                            end else begin
                                err_len <= 1'b1;
                            end
                        end else if (idx == LAST_IDX) begin
                            idx     <= '0;
                            err_len <= 1'b1;
                            state   <= DROP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (accept && in_last) begin
                        idx   <= '0;
                        state <= ACC;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        idx       <= '0;
                        state     <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_clasificador_argmax.sv
// Self-checking bench for clasificador_argmax: table vectors, randomized frames
// against an argmax reference model, plus backpressure and mid-frame reset sequences.
module tb_clasificador_argmax;

    localparam int N = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_class;
    logic [7:0] out_score;
    logic       out_ready = 1'b1;
    logic       err_len;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int len;
        int vals[16];
        int exp_res;
        int exp_err_beat;
        int exp_class;
        int exp_score;
    } vec_t;

    vec_t tbl[8];

    clasificador_argmax #(.NUM_CLASSES(N), .DATA_W(8), .IDX_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_class (out_class),
        .out_score (out_score),
        .out_ready (out_ready),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: frame length decides error/result; winner is the first index holding the maximum ReLU value.
    function automatic void model(input int vals[16], input int len, output int exp_res,
                                  output int exp_err, output int exp_cls, output int exp_score);
        int r[16];
        int best;
        exp_res = 0; exp_err = -1; exp_cls = 0; exp_score = 0;
        if (len < N) exp_err = len - 1;
        else if (len > N) exp_err = N - 1;
        else begin
            exp_res = 1;
            best = 0;
            for (int i = 0; i < N; i++) begin
                r[i] = (vals[i] < 0) ? 0 : vals[i];
                if (r[i] > best) best = r[i];
            end
            for (int i = N - 1; i >= 0; i--)
                if (r[i] == best) exp_cls = i;
            exp_score = best;
        end
    endfunction

    task automatic drive_frame(input int vals[16], input int len, output int err_cnt,
                               output int err_at, output int early_valid);
        err_cnt = 0; err_at = -1; early_valid = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (err_len) begin err_cnt++; err_at = i - 1; end
                if (out_valid) early_valid++;
            end
            in_valid = 1'b1;
            in_data  = vals[i][7:0];
            in_last  = (i == len - 1);
        end
        @(negedge clk);
        if (err_len) begin err_cnt++; err_at = len - 1; end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int vals[16], input int len, input int exp_res,
                               input int exp_err, input int exp_cls, input int exp_score);
        int err_cnt, err_at, early_valid;
        drive_frame(vals, len, err_cnt, err_at, early_valid);
        check({tag, " err_len count"}, err_cnt, (exp_err >= 0) ? 1 : 0);
        check({tag, " err_len beat"}, err_at, exp_err);
        check({tag, " early out_valid"}, early_valid, 0);
        check({tag, " out_valid"}, int'(out_valid), exp_res);
        if (exp_res != 0) begin
            check({tag, " out_class"}, int'(out_class), exp_cls);
            check({tag, " out_score"}, int'(out_score), exp_score);
        end
        @(negedge clk);
        check({tag, " out_valid after accept"}, int'(out_valid), 0);
        if (exp_res != 0) check({tag, " out_class held"}, int'(out_class), exp_cls);
    endtask

    initial begin
        int vals[16];
        int len, er, ee, ec, es;

        // Vectors: inputs plus expected result
        tbl[0].len = 10; tbl[0].vals = '{-5, 3, 7, 2, 7, 0, -128, 1, 6, 4, 0, 0, 0, 0, 0, 0};
        tbl[0].exp_res = 1; tbl[0].exp_err_beat = -1; tbl[0].exp_class = 2; tbl[0].exp_score = 7;
        tbl[1].len = 10; tbl[1].vals = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, 0, 0, 0, 0, 0, 0};
        tbl[1].exp_res = 1; tbl[1].exp_err_beat = -1; tbl[1].exp_class = 0; tbl[1].exp_score = 0;
        tbl[2].len = 5;  tbl[2].vals = '{1, 2, 3, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2].exp_res = 0; tbl[2].exp_err_beat = 4; tbl[2].exp_class = 0; tbl[2].exp_score = 0;
        tbl[3].len = 10; tbl[3].vals = '{10, 20, 30, 40, 50, 60, 70, 80, 100, 90, 0, 0, 0, 0, 0, 0};
        tbl[3].exp_res = 1; tbl[3].exp_err_beat = -1; tbl[3].exp_class = 8; tbl[3].exp_score = 100;
        tbl[4].len = 12; tbl[4].vals = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 120, 125, 0, 0, 0, 0};
        tbl[4].exp_res = 0; tbl[4].exp_err_beat = 9; tbl[4].exp_class = 0; tbl[4].exp_score = 0;
        tbl[5].len = 10; tbl[5].vals = '{127, 3, -128, 4, 5, 6, 7, 8, 9, 127, 0, 0, 0, 0, 0, 0};
        tbl[5].exp_res = 1; tbl[5].exp_err_beat = -1; tbl[5].exp_class = 0; tbl[5].exp_score = 127;
        tbl[6].len = 10; tbl[6].vals = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[6].exp_res = 1; tbl[6].exp_err_beat = -1; tbl[6].exp_class = 9; tbl[6].exp_score = 1;
        tbl[7].len = 10; tbl[7].vals = '{-3, -2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[7].exp_res = 1; tbl[7].exp_err_beat = -1; tbl[7].exp_class = 0; tbl[7].exp_score = 0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("reset in_ready", int'(in_ready), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset err_len", int'(err_len), 0);
        check("reset out_class", int'(out_class), 0);
        check("reset out_score", int'(out_score), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("in_ready after reset", int'(in_ready), 1);

        for (int t = 0; t < 8; t++)
            check_frame($sformatf("vec%0d", t), tbl[t].vals, tbl[t].len, tbl[t].exp_res,
                        tbl[t].exp_err_beat, tbl[t].exp_class, tbl[t].exp_score);

        // Randomized frames against the reference model
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 9))
                0, 1:    len = $urandom_range(1, N - 1);
                2:       len = $urandom_range(N + 1, 14);
                default: len = N;
            endcase
            for (int i = 0; i < 16; i++) begin
                if (t[0]) vals[i] = int'($urandom_range(0, 8)) - 4;
                else      vals[i] = int'($urandom_range(0, 255)) - 128;
            end
            model(vals, len, er, ee, ec, es);
            check_frame($sformatf("rand%0d", t), vals, len, er, ee, ec, es);
        end

        // Backpressure: HOLD ignores offered beats and keeps the result stable
        out_ready = 1'b0;
        vals = '{1, 2, 3, 4, 5, 6, 55, 7, 8, 55, 0, 0, 0, 0, 0, 0};
        drive_frame(vals, N, ee, ec, es);
        check("bp err_len count", ee, 0);
        check("bp out_valid", int'(out_valid), 1);
        check("bp out_class", int'(out_class), 6);
        check("bp out_score", int'(out_score), 55);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'd120;
            in_last  = (k % 2 == 1);
            check($sformatf("bp in_ready %0d", k), int'(in_ready), 0);
            @(negedge clk);
            check($sformatf("bp out_valid %0d", k), int'(out_valid), 1);
            check($sformatf("bp out_class %0d", k), int'(out_class), 6);
            check($sformatf("bp out_score %0d", k), int'(out_score), 55);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp out_valid drop", int'(out_valid), 0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        vals = '{1, 2, 3, 9, 4, 5, 6, 7, 8, 9, 0, 0, 0, 0, 0, 0};
        check_frame("bp next", vals, N, 1, -1, 3, 9);

        // Reset in the middle of a frame
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'd50;
            in_last  = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midrst out_valid", int'(out_valid), 0);
        check("midrst out_class", int'(out_class), 0);
        check("midrst out_score", int'(out_score), 0);
        check("midrst err_len", int'(err_len), 0);
        check("midrst in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("midrst in_ready after", int'(in_ready), 1);
        check_frame("midrst next", tbl[0].vals, tbl[0].len, 1, -1, 2, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clasificador_argmax.md
# clasificador_argmax

Output-stage classifier that sits directly downstream of the layer-1 neuron bank (`neurona_capa_1` instances). It receives one signed 8-bit neuron result per cycle over a valid/ready stream and applies ReLU to each. It tracks the running maximum and its index, then presents the winning class index and score once per frame with a hold-until-accepted handshake. It also detects malformed frame lengths and resynchronises on them.

## Interface
Parameters:
- `NUM_CLASSES`, default 10: neuron results per frame; legal range 2..16.
- `DATA_W`, default 8: width of the signed neuron result.
- `IDX_W`, default 4: class index width; must satisfy 2^IDX_W >= NUM_CLASSES.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_data` / `in_last` valid.
- `in_data` in DATA_W: signed two's-complement neuron result.
- `in_last` in 1: marks the final result of a frame.
- `in_ready` out 1: block accepts a beat this cycle.
- `out_valid` out 1: classification result available.
- `out_class` out IDX_W: index of the winning neuron.
- `out_score` out DATA_W: post-ReLU score of the winner, unsigned in 0..2^(DATA_W-1)-1.
- `out_ready` in 1: consumer accepts the result.
- `err_len` out 1: one-cycle pulse flagging a malformed frame.

## Operation
- A beat is accepted when `in_valid && in_ready` at a rising clock edge.
- ReLU: `r = in_data[DATA_W-1] ? 0 : in_data`.
- Beat counter `idx` (IDX_W bits) counts accepted beats within the frame. It resets to 0 at frame start.
- States are ACC, DROP and HOLD. All outputs are registered except `in_ready`.

ACC:
- `in_ready` = 1.
- The beat at `idx`=0 loads `max` = r and `arg` = 0 unconditionally.
- Any later beat updates `max`/`arg` only if r > `max` (strict). Ties keep the lowest index.

Accepted beat with `in_last`=1:
- If `idx` == NUM_CLASSES-1, the result includes this beat. `out_class`/`out_score` load from the final `arg`/`max`, `out_valid` rises, and the state goes to HOLD.
- If `idx` < NUM_CLASSES-1, the frame is short: `err_len` pulses, the frame is discarded, `idx` = 0, and the state stays ACC.

Accepted beat with `in_last`=0 and `idx` == NUM_CLASSES-1:
- The frame is long: `err_len` pulses, the partial result is discarded, and the state goes to DROP.

DROP:
- `in_ready` = 1. Beats are consumed and ignored.
- The accepted beat with `in_last`=1 moves the state to ACC with `idx` = 0.
- `err_len` does not pulse again in DROP.

HOLD:
- `in_ready` = 0. `out_valid` = 1, and `out_class`/`out_score` are stable.
- When `out_ready`=1, `out_valid` falls on the next edge and the state goes to ACC with `idx` = 0.

Other rules:
- `in_valid` is ignored whenever `in_ready` = 0.
- The comparison is unsigned on the post-ReLU values. No saturation is needed.

## Timing
- Reset (asynchronous assert; deassert is synchronised externally): state = ACC, `idx` = 0, `max` = 0, `arg` = 0, `out_valid` = 0, `out_class` = 0, `out_score` = 0, `err_len` = 0. `in_ready` = 0 while `rst` is high and 1 on the first cycle after.
- Latency: `out_valid` is high in the cycle after the edge that accepted the valid `in_last` beat.
- Throughput: with `out_ready` held high, a frame takes NUM_CLASSES + 1 cycles (NUM_CLASSES accept cycles plus 1 HOLD cycle).
- `out_class`/`out_score` keep their last value after the handshake until the next frame completes.
- `err_len` is high for exactly the cycle after the offending edge.
- Reset mid-frame or in HOLD discards everything. No output is produced for the interrupted frame.
- The upstream neuron has 2-cycle latency. The integrator aligns `in_valid` to it; this block has no internal knowledge of that latency.

## Test plan
1. Full frame, ties keep the lowest index.
   - Stimulus (NUM_CLASSES=10, `out_ready`=1): -5, 3, 7, 2, 7, 0, -128, 1, 6, 4, with `in_last` on beat 9.
   - Required: one cycle later `out_valid`=1, `out_class`=2, `out_score`=7; `err_len` never asserts.
2. All-negative frame.
   - Stimulus: all ten values = -1.
   - Required: `out_class`=0, `out_score`=0.
3. Short frame.
   - Stimulus: `in_last` on beat 4.
   - Required: `err_len` high for 1 cycle and no `out_valid`. A following valid frame with max 100 at index 8 gives `out_class`=8, `out_score`=100.
4. Long frame.
   - Stimulus: 12 beats with `in_last` on beat 11.
   - Required: `err_len` pulses once after beat 9; beats 10–11 are dropped with no `out_valid`. The next frame classifies correctly.
5. Backpressure.
   - Stimulus: hold `out_ready`=0 for 5 cycles after `out_valid`, while driving `in_valid`=1 with data.
   - Required: `in_ready`=0, and `out_valid`/`out_class`/`out_score` are constant. After `out_ready`=1, `out_valid` drops next cycle, and no beats offered during HOLD appear in the next result.
6. Reset mid-frame.
   - Stimulus: assert `rst` after 4 beats.
   - Required: all outputs are 0 immediately. A subsequent full frame produces the correct result with no `err_len`.
